// File: rtl/reg_bank.sv
// Datapath register bank: one-hot loads from the shared bus, one-hot bus drive,
// auto-incrementing program counter, addressed read port and sticky conflict flag.
module reg_bank #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NREGS    = 8,
  parameter int unsigned AW       = 3,
  parameter int unsigned R0_RESET = 2,
  parameter int unsigned PC_RESET = 0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [NREGS-1:0] rin,
  input  logic [NREGS-1:0] rout,
  input  logic             incr_pc,
  input  logic [AW-1:0]    rd_addr,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] pc,
  output logic             err_bus_conflict
);

  localparam int unsigned PCI = NREGS - 1;

  logic [WIDTH-1:0] regs [NREGS];
  logic             multi;

  // x & (x-1) clears the lowest set bit; anything left means >1 bit set
  assign multi = |(rout & (rout - NREGS'(1)));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      regs[0]   <= WIDTH'(R0_RESET);
      regs[PCI] <= WIDTH'(PC_RESET);
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (rin[i]) begin
          regs[i] <= bus_in;
        end
      end
      if (incr_pc && !rin[PCI]) begin
        regs[PCI] <= regs[PCI] + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_bus_conflict <= 1'b0;
    end else if (multi) begin
      err_bus_conflict <= 1'b1;
    end else if (clr_err) begin
      err_bus_conflict <= 1'b0;
    end
  end

  always_comb begin
    bus_out = '0;
    if (!multi) begin
      for (int i = 0; i < NREGS; i++) begin
        if (rout[i]) begin
          bus_out = regs[i];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_data = regs[i];
      end
    end
  end

  assign pc = regs[PCI];

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: stimulus pushes expected outputs from an
// array model, a negedge monitor pops and compares.
module tb_reg_bank;

  logic        clock;
  logic        resetn;
  logic [15:0] bus_in;
  logic [7:0]  rin;
  logic [7:0]  rout;
  logic        incr_pc;
  logic [2:0]  rd_addr;
  logic        clr_err;
  logic [15:0] bus_out;
  logic [15:0] rd_data;
  logic [15:0] pc;
  logic        err_bus_conflict;

  logic [15:0] bo6;
  logic [15:0] rd6;
  logic [15:0] pc6;
  logic        err6;

  reg_bank dut (
    .clock(clock),
    .resetn(resetn),
    .bus_in(bus_in),
    .rin(rin),
    .rout(rout),
    .incr_pc(incr_pc),
    .rd_addr(rd_addr),
    .clr_err(clr_err),
    .bus_out(bus_out),
    .rd_data(rd_data),
    .pc(pc),
    .err_bus_conflict(err_bus_conflict)
  );

  reg_bank #(.NREGS(6)) dut6 (
    .clock(clock),
    .resetn(resetn),
    .bus_in(bus_in),
    .rin(rin[5:0]),
    .rout(rout[5:0]),
    .incr_pc(incr_pc),
    .rd_addr(rd_addr),
    .clr_err(clr_err),
    .bus_out(bo6),
    .rd_data(rd6),
    .pc(pc6),
    .err_bus_conflict(err6)
  );

  typedef struct {
    logic [15:0] bus;
    logic [15:0] rd;
    logic [15:0] pc;
    logic        err;
    logic        chk6;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m [8];
  logic        merr;
  int          vectors = 0;
  int          miscompares = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic void mreset();
    for (int i = 0; i < 8; i++) m[i] = 16'h0000;
    m[0] = 16'h0002;
    m[7] = 16'h0000;
    merr = 1'b0;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.bus = 16'h0000;
    if ($countones(rout) == 1) begin
      for (int i = 0; i < 8; i++) if (rout[i]) e.bus = m[i];
    end
    e.rd   = m[rd_addr];
    e.pc   = m[7];
    e.err  = merr;
    e.chk6 = (rd_addr >= 3'd6);
    return e;
  endfunction

  function automatic void mupdate();
    logic [15:0] old_pc;
    if (!resetn) begin
      mreset();
    end else begin
      old_pc = m[7];
      for (int i = 0; i < 8; i++) if (rin[i]) m[i] = bus_in;
      if (incr_pc && !rin[7]) m[7] = old_pc + 16'd1;
      if ($countones(rout) > 1) merr = 1'b1;
      else if (clr_err) merr = 1'b0;
    end
  endfunction

  task automatic cycle(input logic rn, input logic [7:0] ri,
                       input logic [7:0] ro, input logic inc,
                       input logic [2:0] ra, input logic clr,
                       input logic [15:0] b);
    resetn  = rn;
    rin     = ri;
    rout    = ro;
    incr_pc = inc;
    rd_addr = ra;
    clr_err = clr;
    bus_in  = b;
    if (!rn) mreset();
    q.push_back(predict());
    @(posedge clock);
    mupdate();
    #1;
  endtask

  exp_t e;
  logic bad;

  always @(negedge clock) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      bad = 1'b0;
      if (bus_out !== e.bus) begin
        $display("FAIL bus_out got %h want %h t=%0t", bus_out, e.bus, $time);
        bad = 1'b1;
      end
      if (rd_data !== e.rd) begin
        $display("FAIL rd_data[%0d] got %h want %h t=%0t",
                 rd_addr, rd_data, e.rd, $time);
        bad = 1'b1;
      end
      if (pc !== e.pc) begin
        $display("FAIL pc got %h want %h t=%0t", pc, e.pc, $time);
        bad = 1'b1;
      end
      if (err_bus_conflict !== e.err) begin
        $display("FAIL err_flag got %b want %b t=%0t",
                 err_bus_conflict, e.err, $time);
        bad = 1'b1;
      end
      if (e.chk6 && rd6 !== 16'h0000) begin
        $display("FAIL rd6_oob[%0d] got %h want 0000 t=%0t",
                 rd_addr, rd6, $time);
        bad = 1'b1;
      end
      if (bad) miscompares++;
    end
  end

  initial begin
    logic [7:0] ri;
    logic [7:0] ro;
    int         k;
    resetn  = 1'b0;
    rin     = '0;
    rout    = '0;
    incr_pc = 1'b0;
    rd_addr = '0;
    clr_err = 1'b0;
    bus_in  = '0;
    mreset();
    @(posedge clock);
    #1;
    cycle(0, 8'h00, 8'h01, 0, 3'd0, 0, 16'h0);
    cycle(0, 8'hff, 8'h00, 1, 3'd7, 0, 16'h5555);
    cycle(1, 8'h08, 8'h00, 0, 3'd3, 0, 16'hBEEF);
    cycle(1, 8'h00, 8'h08, 0, 3'd3, 0, 16'h0000);
    // reset asserted just after an edge; checked before the next edge
    cycle(0, 8'h08, 8'h08, 1, 3'd3, 0, 16'h1111);
    cycle(1, 8'h00, 8'h08, 0, 3'd3, 0, 16'h0000);
    cycle(1, 8'h80, 8'h00, 0, 3'd7, 0, 16'hFFFF);
    cycle(1, 8'h00, 8'h80, 1, 3'd7, 0, 16'h0000);
    cycle(1, 8'h80, 8'h00, 1, 3'd7, 0, 16'h0040);
    cycle(1, 8'h00, 8'h00, 0, 3'd7, 0, 16'h0000);
    cycle(1, 8'h06, 8'h00, 0, 3'd1, 0, 16'h1234);
    cycle(1, 8'h00, 8'h06, 0, 3'd2, 0, 16'h0000);
    cycle(1, 8'h00, 8'h02, 0, 3'd1, 0, 16'h0000);
    cycle(1, 8'h00, 8'h04, 0, 3'd2, 1, 16'h0000);
    cycle(1, 8'h00, 8'h00, 0, 3'd0, 0, 16'h0000);
    cycle(1, 8'h00, 8'h03, 0, 3'd0, 1, 16'h0000);
    cycle(1, 8'h00, 8'h00, 0, 3'd0, 0, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 8'(1 << i), 8'h00, 0, 3'd0, 0, 16'(i * 16'h1111));
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1, 8'h00, 8'(1 << i), 0, 3'(i), 0, 16'h0000);
    end
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 3));
      if (k == 0) ro = 8'h00;
      else if (k < 3) ro = 8'(1 << $urandom_range(0, 7));
      else begin
        ro = 8'($urandom);
        while ($countones(ro) < 2) ro = 8'($urandom);
      end
      k = int'($urandom_range(0, 5));
      if (k < 2) ri = 8'(1 << $urandom_range(0, 7));
      else if (k == 2) ri = 8'($urandom);
      else ri = 8'h00;
      cycle(($urandom_range(0, 49) != 0), ri, ro,
            ($urandom_range(0, 2) == 0), 3'($urandom),
            ($urandom_range(0, 4) == 0), 16'($urandom));
    end
    @(negedge clock);
    #1;
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain left %0d want 0", q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
